// File: rtl/seq_alu_datapath.sv
// seq_alu_datapath
//   Runs one add/sub transaction per accepted start. Operands are written into
//   an internal data memory (DM), moved into an internal register file (RF),
//   combined by a signed add/sub unit, and the result is written back to DM.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      transaction request, accepted only while idle
//   op         0 = A+B, 1 = A-B
//   num_a/b    operands A and B
//   dm_addr_a  DM slot for A           dm_addr_b  DM slot for B
//   dm_addr_r  DM slot for the result  rf_addr_a/b RF registers for A/B
//   rd_addr    debug DM read address   rd_data    dm[rd_addr], combinational
//   busy       high whenever not idle  done       one-cycle result-valid pulse
//   result     last result, held       overflow   signed overflow of result

module seq_alu_datapath #(
  parameter int unsigned WORDSIZE = 64,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                op,
  input  logic [WORDSIZE-1:0] num_a,
  input  logic [WORDSIZE-1:0] num_b,
  input  logic [ADDR_W-1:0]   dm_addr_a,
  input  logic [ADDR_W-1:0]   dm_addr_b,
  input  logic [ADDR_W-1:0]   dm_addr_r,
  input  logic [ADDR_W-1:0]   rf_addr_a,
  input  logic [ADDR_W-1:0]   rf_addr_b,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [WORDSIZE-1:0] rd_data,
  output logic                busy,
  output logic                done,
  output logic [WORDSIZE-1:0] result,
  output logic                overflow
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    StIdle,
    StWrA,
    StLdA,
    StWrB,
    StLdB,
    StExec,
    StWb
  } state_e;

  state_e state_q, state_d;

  // Transaction inputs captured at the accept edge.
  logic                op_q;
  logic [WORDSIZE-1:0] num_a_q, num_b_q;
  logic [ADDR_W-1:0]   dm_a_q, dm_b_q, dm_r_q, rf_a_q, rf_b_q;

  logic [WORDSIZE-1:0] dm_q [Depth];
  logic [WORDSIZE-1:0] rf_q [Depth];

  logic                dm_we, rf_we;
  logic [ADDR_W-1:0]   dm_waddr, rf_waddr;
  logic [WORDSIZE-1:0] dm_wdata, rf_wdata;

  logic [WORDSIZE-1:0] result_q, result_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;

  logic [WORDSIZE-1:0] alu_a, alu_b, alu_r;
  logic                accept;

  assign accept = (state_q == StIdle) && start;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StWrA;
      StWrA:   state_d = StLdA;
      StLdA:   state_d = StWrB;
      StWrB:   state_d = StLdB;
      StLdB:   state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory write ports, one write per state at most.
  always_comb begin
    dm_we    = 1'b0;
    dm_waddr = dm_a_q;
    dm_wdata = num_a_q;
    rf_we    = 1'b0;
    rf_waddr = rf_a_q;
    rf_wdata = dm_q[dm_a_q];
    unique case (state_q)
      StWrA: dm_we = 1'b1;
      StLdA: rf_we = 1'b1;
      StWrB: begin
        dm_we    = 1'b1;
        dm_waddr = dm_b_q;
        dm_wdata = num_b_q;
      end
      StLdB: begin
        rf_we    = 1'b1;
        rf_waddr = rf_b_q;
        rf_wdata = dm_q[dm_b_q];
      end
      StWb: begin
        dm_we    = 1'b1;
        dm_waddr = dm_r_q;
        dm_wdata = result_q;
      end
      default: ;
    endcase
  end

  // Add/sub unit with signed overflow detection.
  always_comb begin
    alu_a = rf_q[rf_a_q];
    alu_b = rf_q[rf_b_q];
    alu_r = op_q ? (alu_a - alu_b) : (alu_a + alu_b);

    result_d   = result_q;
    overflow_d = overflow_q;
    done_d     = (state_q == StWb);
    if (state_q == StExec) begin
      result_d = alu_r;
      if (op_q) begin
        overflow_d = (alu_a[WORDSIZE-1] != alu_b[WORDSIZE-1]) &&
                     (alu_r[WORDSIZE-1] != alu_a[WORDSIZE-1]);
      end else begin
        overflow_d = (alu_a[WORDSIZE-1] == alu_b[WORDSIZE-1]) &&
                     (alu_r[WORDSIZE-1] != alu_a[WORDSIZE-1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      result_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op;
      num_a_q <= num_a;
      num_b_q <= num_b;
      dm_a_q  <= dm_addr_a;
      dm_b_q  <= dm_addr_b;
      dm_r_q  <= dm_addr_r;
      rf_a_q  <= rf_addr_a;
      rf_b_q  <= rf_addr_b;
    end
  end

  // Storage is never cleared; reset only suppresses writes still pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (dm_we) dm_q[dm_waddr] <= dm_wdata;
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign rd_data  = dm_q[rd_addr];
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_alu_datapath.sv
module tb_seq_alu_datapath;

  localparam int unsigned W   = 64;
  localparam int unsigned AW  = 5;
  localparam int unsigned W2  = 16;
  localparam int unsigned AW2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, op;
  logic [W-1:0]  num_a, num_b, rd_data, result;
  logic [AW-1:0] dm_addr_a, dm_addr_b, dm_addr_r, rf_addr_a, rf_addr_b, rd_addr;
  logic          busy, done, overflow;

  logic           start_s, op_s;
  logic [W2-1:0]  num_a_s, num_b_s, rd_data_s, result_s;
  logic [AW2-1:0] dm_addr_a_s, dm_addr_b_s, dm_addr_r_s, rf_addr_a_s, rf_addr_b_s, rd_addr_s;
  logic           busy_s, done_s, overflow_s;

  int checks = 0;
  int errors = 0;

  seq_alu_datapath #(.WORDSIZE(W), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .num_a(num_a), .num_b(num_b),
    .dm_addr_a(dm_addr_a), .dm_addr_b(dm_addr_b), .dm_addr_r(dm_addr_r),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .result(result), .overflow(overflow)
  );

  seq_alu_datapath #(.WORDSIZE(W2), .ADDR_W(AW2)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .op(op_s), .num_a(num_a_s), .num_b(num_b_s),
    .dm_addr_a(dm_addr_a_s), .dm_addr_b(dm_addr_b_s), .dm_addr_r(dm_addr_r_s),
    .rf_addr_a(rf_addr_a_s), .rf_addr_b(rf_addr_b_s), .rd_addr(rd_addr_s),
    .rd_data(rd_data_s), .busy(busy_s), .done(done_s), .result(result_s),
    .overflow(overflow_s)
  );

  task automatic set_txn(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] da, input logic [AW-1:0] db,
                         input logic [AW-1:0] dr, input logic [AW-1:0] ra,
                         input logic [AW-1:0] rb);
    op = o; num_a = a; num_b = b;
    dm_addr_a = da; dm_addr_b = db; dm_addr_r = dr;
    rf_addr_a = ra; rf_addr_b = rb;
  endtask

  // Called at a negedge with inputs set. Returns edges from accept to done (-1 on timeout).
  // Inputs are scrambled after the accept edge to show they were captured.
  task automatic run_txn(output int lat);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op = ~op; num_a = ~num_a; num_b = ~num_b;
    dm_addr_a = ~dm_addr_a; dm_addr_b = ~dm_addr_b; dm_addr_r = ~dm_addr_r;
    rf_addr_a = ~rf_addr_a; rf_addr_b = ~rf_addr_b;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; start_s = 1'b0;
    set_txn(1'b0, '0, '0, '0, '0, '0, '0, '0);
    rd_addr = '0;
    op_s = 1'b0; num_a_s = '0; num_b_s = '0; rd_addr_s = '0;
    dm_addr_a_s = '0; dm_addr_b_s = '0; dm_addr_r_s = '0; rf_addr_a_s = '0; rf_addr_b_s = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, overflow, result} !== {3'b000, 64'h0}) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b ovf=%b res=%h exp 0 0 0 0",
               busy, done, overflow, result);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add;
    int lat;
    set_txn(1'b0, 64'd5, 64'd7, 5'd0, 5'd1, 5'd2, 5'd0, 5'd1);
    run_txn(lat);
    checks++;
    if (lat !== 6) begin
      errors++; $display("FAIL add_latency got %0d exp 6", lat);
    end
    checks++;
    if ({overflow, result} !== {1'b0, 64'd12}) begin
      errors++; $display("FAIL add_result got ovf=%b res=%h exp 0 %h", overflow, result, 64'd12);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL add_busy_in_done got %b exp 0", busy);
    end
    rd_addr = 5'd2;
    @(negedge clk);
    checks++;
    if (rd_data !== 64'd12) begin
      errors++; $display("FAIL add_writeback got %h exp %h", rd_data, 64'd12);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL add_done_pulse got %b exp 0", done);
    end
  endtask

  task automatic test_sub_ovf;
    int lat;
    set_txn(1'b1, 64'd3, 64'd10, 5'd3, 5'd4, 5'd8, 5'd2, 5'd3);
    run_txn(lat);
    checks++;
    if ({lat == 6, overflow, result} !== {1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9}) begin
      errors++; $display("FAIL sub_neg got lat=%0d ovf=%b res=%h exp 6 0 fffffffffffffff9",
                         lat, overflow, result);
    end
    @(negedge clk);
    set_txn(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, 5'd4, 5'd8, 5'd2, 5'd3);
    run_txn(lat);
    checks++;
    if ({lat == 6, overflow, result} !== {1'b1, 1'b1, 64'h8000_0000_0000_0000}) begin
      errors++; $display("FAIL add_ovf got lat=%0d ovf=%b res=%h exp 6 1 8000000000000000",
                         lat, overflow, result);
    end
    @(negedge clk);
    set_txn(1'b1, 64'h8000_0000_0000_0000, 64'd1, 5'd3, 5'd4, 5'd8, 5'd2, 5'd3);
    run_txn(lat);
    checks++;
    if ({overflow, result} !== {1'b1, 64'h7FFF_FFFF_FFFF_FFFF}) begin
      errors++; $display("FAIL sub_ovf got ovf=%b res=%h exp 1 7fffffffffffffff",
                         overflow, result);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    int ndone = 0;
    int lat;
    set_txn(1'b0, 64'd100, 64'd23, 5'd10, 5'd11, 5'd12, 5'd4, 5'd5);
    start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
      start = (i == 2 || i == 4);
      num_a = 64'd1000;
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1) begin
      errors++; $display("FAIL busy_ignore_dones got %0d exp 1", ndone);
    end
    checks++;
    if (result !== 64'd123) begin
      errors++; $display("FAIL busy_ignore_result got %h exp %h", result, 64'd123);
    end
    // Back-to-back: second start issued in the first transaction's done cycle.
    set_txn(1'b0, 64'd1, 64'd2, 5'd13, 5'd14, 5'd15, 5'd6, 5'd7);
    run_txn(lat);
    checks++;
    if ({lat == 6, result} !== {1'b1, 64'd3}) begin
      errors++; $display("FAIL b2b_first got lat=%0d res=%h exp 6 3", lat, result);
    end
    set_txn(1'b1, 64'd50, 64'd8, 5'd16, 5'd17, 5'd18, 5'd8, 5'd9);
    run_txn(lat);
    checks++;
    if ({lat == 6, result} !== {1'b1, 64'd42}) begin
      errors++; $display("FAIL b2b_second got lat=%0d res=%h exp 6 2a", lat, result);
    end
    @(negedge clk);
  endtask

  task automatic test_alias;
    int lat;
    set_txn(1'b0, 64'd9, 64'd4, 5'd5, 5'd6, 5'd5, 5'd3, 5'd3);
    run_txn(lat);
    checks++;
    if ({lat == 6, result} !== {1'b1, 64'd8}) begin
      errors++; $display("FAIL rf_alias got lat=%0d res=%h exp 6 8", lat, result);
    end
    rd_addr = 5'd5;
    @(negedge clk);
    checks++;
    if (rd_data !== 64'd8) begin
      errors++; $display("FAIL dm_r_alias got %h exp 8", rd_data);
    end
    set_txn(1'b1, 64'd20, 64'd30, 5'd7, 5'd7, 5'd19, 5'd1, 5'd2);
    run_txn(lat);
    checks++;
    if (result !== 64'hFFFF_FFFF_FFFF_FFF6) begin
      errors++; $display("FAIL dm_ab_alias got %h exp fffffffffffffff6", result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int ndone = 0;
    // Slot 20 holds 0x11 afterwards: 0x10 + 1.
    set_txn(1'b0, 64'h10, 64'h1, 5'd21, 5'd22, 5'd20, 5'd10, 5'd11);
    begin
      int lat;
      run_txn(lat);
    end
    @(negedge clk);
    // Abort before WR_B would overwrite slot 20.
    set_txn(1'b0, 64'h5, 64'hDEAD, 5'd23, 5'd20, 5'd24, 5'd12, 5'd13);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, overflow, result} !== {3'b000, 64'h0}) begin
      errors++;
      $display("FAIL reset_mid_state got busy=%b done=%b ovf=%b res=%h exp 0 0 0 0",
               busy, done, overflow, result);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++; $display("FAIL reset_mid_no_done got %0d exp 0", ndone);
    end
    rd_addr = 5'd20;
    #1;
    checks++;
    if (rd_data !== 64'h11) begin
      errors++; $display("FAIL reset_mid_no_write got %h exp 11", rd_data);
    end
  endtask

  task automatic test_small;
    int lat = 0;
    logic [3:0] nine = 4'd9;
    op_s = 1'b1; num_a_s = 16'h7FFF; num_b_s = 16'hFFFF;
    dm_addr_a_s = 3'd2; dm_addr_b_s = 3'd3; dm_addr_r_s = nine[2:0];
    rf_addr_a_s = 3'd0; rf_addr_b_s = 3'd1;
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    num_a_s = '0; num_b_s = '0; op_s = 1'b0;
    while (!done_s && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if ({lat == 6, overflow_s, result_s} !== {1'b1, 1'b1, 16'h8000}) begin
      errors++; $display("FAIL small_sub_ovf got lat=%0d ovf=%b res=%h exp 6 1 8000",
                         lat, overflow_s, result_s);
    end
    rd_addr_s = 3'd1;
    @(negedge clk);
    checks++;
    if (rd_data_s !== 16'h8000) begin
      errors++; $display("FAIL small_wrap_wb got %h exp 8000", rd_data_s);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_ovf();
    test_busy_ignore();
    test_alias();
    test_reset_mid();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
